// File: rtl/sweep_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sweep_mult_ctrl_if
// Description : Bundles the requester-side and adder-side signals of the
//               sweep multiplier controller.
//               slave  : the controller's view.
//               master : the environment's view (requester plus adder).
//               Requester side : start, multiplier, multiplicand ->
//                                busy, valid, result, err
//               Adder side     : add_done, add_product ->
//                                init_fsm, l_s, permit, rgstr1, rgstr2
// Revision    : 1.0 - initial release
// ============================================================================
interface sweep_mult_ctrl_if #(
  parameter int DW   = 8,
  parameter int DW_2 = 2 * DW
);
  // requester side
  logic            start;
  logic [DW-1:0]   multiplier;
  logic [DW-1:0]   multiplicand;
  logic            busy;
  logic            valid;
  logic [DW_2-1:0] result;
  logic            err;
  // adder side
  logic            add_done;
  logic [DW_2-1:0] add_product;
  logic            init_fsm;
  logic            l_s;
  logic            permit;
  logic [DW-1:0]   rgstr1;
  logic [DW_2-1:0] rgstr2;

  modport slave (
    input  start, multiplier, multiplicand, add_done, add_product,
    output busy, valid, result, err, init_fsm, l_s, permit, rgstr1, rgstr2
  );

  modport master (
    output start, multiplier, multiplicand, add_done, add_product,
    input  busy, valid, result, err, init_fsm, l_s, permit, rgstr1, rgstr2
  );
endinterface
`default_nettype wire

// File: rtl/sweep_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sweep_mult_ctrl
// Description : Sequences a sweep_sequential_adder to form one signed DWxDW
//               product per request.
//               Operands are converted to magnitudes at the accepting edge.
//               The adder is swept for DW cycles.
//               The adder's residual accumulator value is removed, and the
//               sign is restored.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               bus  - sweep_mult_ctrl_if.slave
//                      start/multiplier/multiplicand in
//                      add_done/add_product in (from adder)
//                      init_fsm/l_s/permit/rgstr1/rgstr2 out (to adder)
//                      busy/valid/result/err out (to requester)
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_mult_ctrl #(
  parameter int DW      = 8,
  parameter int DW_2    = 2 * DW,
  parameter int DWlogb2 = $clog2(DW)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sweep_mult_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ACC  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [DWlogb2:0] c_k_last = (DWlogb2 + 1)'(DW - 1);

  state_t           r_state;
  state_t           w_next;

  logic             r_sign;
  logic [DWlogb2:0] r_k;
  logic [DW_2-1:0]  r_base;
  logic [DW-1:0]    r_rgstr1;
  logic [DW_2-1:0]  r_rgstr2;
  logic [DW_2-1:0]  r_result;
  logic             r_err;

  logic             r_init_fsm, r_l_s, r_permit, r_busy, r_valid;
  logic             w_init_fsm, w_l_s, w_permit, w_busy, w_valid;

  logic             w_accept;
  logic [DW-1:0]    w_abs_a;
  logic [DW-1:0]    w_abs_b;
  logic [DW_2-1:0]  w_mag;

  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // The most negative operand maps to 2^(DW-1), which is still representable
  // as a DW-bit unsigned magnitude.
  assign w_abs_a = bus.multiplier[DW-1]   ? (~bus.multiplier + 1'b1)   : bus.multiplier;
  assign w_abs_b = bus.multiplicand[DW-1] ? (~bus.multiplicand + 1'b1) : bus.multiplicand;

  // The adder never clears its accumulator. The value captured at the end of
  // LOAD is a residue that must be removed from the final sum.
  assign w_mag = bus.add_product - r_base;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // Next state, plus control outputs decoded from the next state. The outputs
  // are then registered, so they line up with the state they describe.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_init_fsm = 1'b0;
    w_l_s      = 1'b0;
    w_permit   = 1'b1;
    w_busy     = 1'b0;
    w_valid    = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next = S_LOAD;
      S_LOAD:         w_next = S_ACC;
      S_ACC:          if (r_k == c_k_last) w_next = S_FIX;
      S_FIX:          w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase

    case (w_next)
      S_LOAD: begin
        w_init_fsm = 1'b1;
        w_l_s      = 1'b1;
        w_permit   = 1'b0;
        w_busy     = 1'b1;
      end
      S_ACC: begin
        w_init_fsm = 1'b1;
        w_permit   = 1'b0;
        w_busy     = 1'b1;
      end
      S_FIX: begin
        w_init_fsm = 1'b1;
        w_busy     = 1'b1;
      end
      S_DONE: begin
        w_init_fsm = 1'b1;
        w_valid    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_fsm <= 1'b0;
      r_l_s      <= 1'b0;
      r_permit   <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_init_fsm <= w_init_fsm;
      r_l_s      <= w_l_s;
      r_permit   <= w_permit;
      r_busy     <= w_busy;
      r_valid    <= w_valid;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign   <= 1'b0;
      r_k      <= '0;
      r_base   <= '0;
      r_rgstr1 <= '0;
      r_rgstr2 <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_sign   <= bus.multiplier[DW-1] ^ bus.multiplicand[DW-1];
            r_rgstr1 <= w_abs_a;
            r_rgstr2 <= {{(DW_2 - DW){1'b0}}, w_abs_b};
            r_k      <= '0;
            r_err    <= 1'b0;
          end
        end
        S_LOAD: r_base <= bus.add_product;
        S_ACC: begin
          // During sweep step k, the adder sees |B| << k.
          r_rgstr2 <= r_rgstr2 << 1;
          r_k      <= r_k + 1'b1;
        end
        S_FIX: begin
          r_result <= r_sign ? ({DW_2{1'b0}} - w_mag) : w_mag;
          // add_done can be stale-high earlier in a back-to-back run, so it
          // is only trusted here.
          if (!bus.add_done) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.init_fsm = r_init_fsm;
  assign bus.l_s      = r_l_s;
  assign bus.permit   = r_permit;
  assign bus.busy     = r_busy;
  assign bus.valid    = r_valid;
  assign bus.rgstr1   = r_rgstr1;
  assign bus.rgstr2   = r_rgstr2;
  assign bus.result   = r_result;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sweep_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_mult_ctrl
// Description : Self-checking bench for sweep_mult_ctrl.
//               A behavioural sweep adder is included, and its accumulator is
//               never cleared.
//               Expected products are queued at each accepted start and
//               compared when valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_mult_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   force_low;

  logic [15:0] exp_q[$];
  logic [15:0] exp;
  int          lat;

  sweep_mult_ctrl_if #(.DW(8), .DW_2(16)) bus ();

  sweep_mult_ctrl #(.DW(8), .DW_2(16), .DWlogb2(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder. l_s restarts the bit counter only. An ACC cycle adds
  // rgstr2 when bit k of rgstr1 is set. done rises on the last step and is
  // otherwise left as it was.
  logic [15:0] m_acc;
  logic [3:0]  m_cnt;
  logic        m_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc  <= '0;
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (bus.init_fsm && bus.l_s) begin
      m_cnt <= '0;
    end else if (bus.init_fsm && !bus.permit) begin
      if (bus.rgstr1[m_cnt[2:0]]) m_acc <= m_acc + bus.rgstr2;
      m_cnt  <= m_cnt + 4'd1;
      m_done <= (m_cnt == 4'd7);
    end
  end

  assign bus.add_product = m_acc;
  assign bus.add_done    = m_done & ~force_low;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic signed [7:0] a, input logic signed [7:0] b, input bit push);
    bus.start        = 1'b1;
    bus.multiplier   = a;
    bus.multiplicand = b;
    if (push) exp_q.push_back(16'(int'(a) * int'(b)));
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    checks++; if ({bus.init_fsm, bus.l_s, bus.permit} !== 3'b001) begin errors++; $display("FAIL reset_ctl: got %b expected 001", {bus.init_fsm, bus.l_s, bus.permit}); end
    checks++; if (bus.rgstr1 !== 8'd0 || bus.rgstr2 !== 16'd0) begin errors++; $display("FAIL reset_rgstr: got %h/%h expected 0/0", bus.rgstr1, bus.rgstr2); end
    checks++; if (bus.result !== 16'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    checks++; if ({bus.busy, bus.valid, bus.err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {bus.busy, bus.valid, bus.err}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    do_start(8'sd3, 8'sd5, 1'b1);
    checks++; if ({bus.init_fsm, bus.l_s, bus.permit, bus.busy} !== 4'b1101) begin errors++; $display("FAIL load_ctl: got %b expected 1101", {bus.init_fsm, bus.l_s, bus.permit, bus.busy}); end
    checks++; if (bus.rgstr1 !== 8'd3 || bus.rgstr2 !== 16'd5) begin errors++; $display("FAIL load_rgstr: got %0d/%0d expected 3/5", bus.rgstr1, bus.rgstr2); end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (bus.rgstr2 !== 16'(5 << k)) begin errors++; $display("FAIL acc_rgstr2 k=%0d: got %0d expected %0d", k, bus.rgstr2, 5 << k); end
      checks++; if ({bus.init_fsm, bus.l_s, bus.permit, bus.valid} !== 4'b1000) begin errors++; $display("FAIL acc_ctl k=%0d: got %b expected 1000", k, {bus.init_fsm, bus.l_s, bus.permit, bus.valid}); end
    end
    tick();
    checks++; if ({bus.permit, bus.busy, bus.valid} !== 3'b110) begin errors++; $display("FAIL fix_ctl: got %b expected 110", {bus.permit, bus.busy, bus.valid}); end
    tick();
    checks++; if ({bus.valid, bus.busy} !== 2'b10) begin errors++; $display("FAIL done_latency: valid/busy got %b expected 10", {bus.valid, bus.busy}); end
    exp = exp_q.pop_front();
    checks++; if (bus.result !== exp || bus.err !== 1'b0) begin errors++; $display("FAIL basic_result: got %h err %b expected %h err 0", bus.result, bus.err, exp); end
  endtask

  task automatic test_back_to_back;
    // Started in the first DONE cycle left by test_basic; the accumulator
    // still holds 15 and add_done is stale-high.
    do_start(8'sd4, 8'sd4, 1'b1);
    checks++; if ({bus.busy, bus.valid, bus.err} !== 3'b100) begin errors++; $display("FAIL b2b_load: got %b expected 100", {bus.busy, bus.valid, bus.err}); end
    wait_valid(lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL b2b_latency: got %0d expected 10", lat); end
    exp = exp_q.pop_front();
    checks++; if (bus.result !== exp || bus.err !== 1'b0) begin errors++; $display("FAIL b2b_result: got %h err %b expected %h err 0", bus.result, bus.err, exp); end
  endtask

  task automatic test_signs;
    logic signed [7:0] ta[6] = '{-8'sd7, 8'sd6, -8'sd128, -8'sd128, 8'sd0, 8'sd127};
    logic signed [7:0] tb[6] = '{8'sd6, -8'sd7, -8'sd128, 8'sd127, -8'sd5, 8'sd127};
    for (int i = 0; i < 6; i++) begin
      do_start(ta[i], tb[i], 1'b1);
      wait_valid(lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL signs_latency %0d: got %0d expected 10", i, lat); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp || bus.err !== 1'b0) begin errors++; $display("FAIL signs_result %0d: got %h err %b expected %h err 0", i, bus.result, bus.err, exp); end
    end
  endtask

  task automatic test_ignore_start;
    do_start(8'sd3, 8'sd5, 1'b1);
    tick(); tick(); tick();
    do_start(8'sd9, 8'sd9, 1'b0);
    checks++; if (bus.busy !== 1'b1 || bus.rgstr1 !== 8'd3) begin errors++; $display("FAIL ignore_busy: got busy %b rgstr1 %0d expected 1/3", bus.busy, bus.rgstr1); end
    wait_valid(lat);
    exp = exp_q.pop_front();
    checks++; if (bus.valid !== 1'b1 || bus.result !== exp) begin errors++; $display("FAIL ignore_result: got %h valid %b expected %h", bus.result, bus.valid, exp); end
  endtask

  task automatic test_reset_mid;
    do_start(8'sd7, 8'sd7, 1'b0);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if ({bus.init_fsm, bus.l_s, bus.permit, bus.busy, bus.valid, bus.err} !== 6'b001000) begin errors++; $display("FAIL midrst_ctl: got %b expected 001000", {bus.init_fsm, bus.l_s, bus.permit, bus.busy, bus.valid, bus.err}); end
    checks++; if (bus.rgstr1 !== 8'd0 || bus.rgstr2 !== 16'd0 || bus.result !== 16'd0) begin errors++; $display("FAIL midrst_data: got %h/%h/%h expected 0/0/0", bus.rgstr1, bus.rgstr2, bus.result); end
    tick();
    rst = 1'b1;
    tick();
    do_start(-8'sd3, 8'sd11, 1'b1);
    wait_valid(lat);
    exp = exp_q.pop_front();
    checks++; if (bus.valid !== 1'b1 || bus.result !== exp || bus.err !== 1'b0) begin errors++; $display("FAIL midrst_result: got %h valid %b err %b expected %h", bus.result, bus.valid, bus.err, exp); end
  endtask

  task automatic test_err;
    force_low = 1'b1;
    do_start(8'sd2, 8'sd3, 1'b1);
    wait_valid(lat);
    exp = exp_q.pop_front();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus.err); end
    checks++; if (bus.result !== exp) begin errors++; $display("FAIL err_result: got %h expected %h", bus.result, exp); end
    force_low = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.err !== 1'b1 || bus.valid !== 1'b1) begin errors++; $display("FAIL err_sticky: got err %b valid %b expected 1/1", bus.err, bus.valid); end
    do_start(8'sd5, 8'sd5, 1'b1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", bus.err); end
    wait_valid(lat);
    exp = exp_q.pop_front();
    checks++; if (bus.result !== exp || bus.err !== 1'b0) begin errors++; $display("FAIL err_next: got %h err %b expected %h err 0", bus.result, bus.err, exp); end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    force_low        = 1'b0;
    rst              = 1'b0;
    bus.start        = 1'b0;
    bus.multiplier   = '0;
    bus.multiplicand = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_signs();
    test_ignore_start();
    test_reset_mid();
    test_err();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sweep_mult_ctrl.md
# sweep_mult_ctrl

Control unit that sequences the `sweep_sequential_adder` accumulator to perform one signed DW×DW multiplication per request. It captures operands on a start pulse and converts them to magnitudes. It drives `l_s`/`init_FSM`/`permit` and presents the shifted multiplicand on `rgstr2` each cycle. It removes the adder's residual accumulator value, restores the sign, and holds the product for the requester.

## Interface
- `DW`, 8: operand width (two's complement).
- `DW_2`, 2*DW: product width; must equal the adder's DW_2.
- `DWlogb2`, $clog2(DW): width of the internal sweep counter (DWlogb2+1 bits).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse; accepted only in IDLE or DONE.
- `multiplier`  in  DW  signed operand A.
- `multiplicand`  in  DW  signed operand B.
- `add_done`  in  1  adder `done`.
- `add_product`  in  DW_2  adder `product`.
- `init_fsm`  out  1  to adder `init_FSM`.
- `l_s`  out  1  to adder `l_s`.
- `permit`  out  1  to adder `permit`.
- `rgstr1`  out  DW  to adder; |A|.
- `rgstr2`  out  DW_2  to adder; |B| << k during sweep step k.
- `busy`  out  1  high in LOAD, ACC, FIX.
- `valid`  out  1  high in DONE; `result` is stable while high.
- `result`  out  DW_2  signed product A*B.
- `err`  out  1  sticky; set when `add_done` is low in FIX; cleared by the next accepted start.

## Operation
- States: IDLE, LOAD, ACC, FIX, DONE.
- IDLE/DONE + `start` -> LOAD. On this edge:
  - Capture sign = A[DW-1]^B[DW-1].
  - `rgstr1` <= |A|, as DW-bit unsigned; -2^(DW-1) maps to 2^(DW-1).
  - `rgstr2` <= zero-extended |B|.
  - `k` <= 0; `err` <= 0.
- LOAD (1 cycle): `init_fsm`=1, `l_s`=1, `permit`=0. On exit, `base` <= `add_product`. The adder does not clear its accumulator, so `base` holds its residual value. -> ACC.
- ACC (exactly DW cycles, k=0..DW-1): `init_fsm`=1, `l_s`=0, `permit`=0.
  - Each edge: `rgstr2` <= `rgstr2`<<1, `k` <= `k`+1.
  - k==DW-1 -> FIX.
  - `permit` must not stay low past DW cycles; otherwise the adder re-adds bit DW-1.
- FIX (1 cycle): `init_fsm`=1, `permit`=1, `l_s`=0.
  - mag = `add_product` - `base` (mod 2^DW_2).
  - `result` <= sign ? -mag : mag.
  - If `add_done`==0, `err` <= 1.
  - -> DONE.
- DONE: `permit`=1, `init_fsm`=1; hold `result`, `valid`=1 until an accepted start.
- IDLE: `init_fsm`=0, `l_s`=0, `permit`=1, `rgstr1`/`rgstr2` hold.
- `start` in LOAD/ACC/FIX is ignored; there is no queueing.
- `add_done` is not used to terminate ACC. It is stale-high during LOAD and the first ACC cycle of back-to-back operations, so it is only checked in FIX.

## Timing
- Reset values:
  - State IDLE.
  - `init_fsm`=0, `l_s`=0, `permit`=1.
  - `rgstr1`=0, `rgstr2`=0, `result`=0.
  - `busy`=0, `valid`=0, `err`=0.
  - Internal `base`, `k` and sign cleared.
- Reset mid-operation aborts to IDLE immediately. The adder shares `rst`, so `base`=0 after reset.
- Latency: start sampled at edge E0 -> `valid` high after edge E0+DW+2 (10 cycles for DW=8).
- Next start is accepted in the first DONE cycle. Throughput is one product per DW+2 cycles.
- Operands are sampled only at the accepting edge and may change afterwards.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- A=3, B=5, DW=8 -> `valid` 10 cycles after start, `result`=15, `err`=0, `rgstr2` sequence 5,10,20,…,640.
- A=-7, B=6 -> `result`=16'hFFD6 (-42); A=6, B=-7 -> same.
- A=-128, B=-128 -> `result`=16384; A=-128, B=127 -> -16256; A=0, B=-5 -> 0.
- Back-to-back 3*5, then 4*4 started in the first DONE cycle. The adder accumulator reaches 31; `result`=16 via base subtraction. `add_done` is stale-high during the second LOAD, and `err` stays 0.
- `start` pulsed during ACC with new operands -> ignored; the original product is delivered. `rst` low mid-ACC -> all outputs return to reset values; the next start yields a correct product.
- `add_done` forced low in FIX -> `err`=1 sticky until the next accepted start.
